// File: rtl/series_pkg.sv
// series_pkg: shared types for the series frame loader.
//   loader_state_t     : FILL / LAUNCH / WAIT_DONE loader states
//   DEFAULT_DATA_WIDTH : default word width of the frame stream
//   data_word_t        : one stream word at the default width
package series_pkg;

    typedef enum logic [1:0] {
        FILL      = 2'd0,
        LAUNCH    = 2'd1,
        WAIT_DONE = 2'd2
    } loader_state_t;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;

    typedef logic [DEFAULT_DATA_WIDTH-1:0] data_word_t;

endpackage : series_pkg

// File: rtl/series_frame_loader.sv
// series_frame_loader: packs a valid/ready word stream into an N-word frame,
// launches the series summer with a one-cycle start pulse, and then freezes the
// frame until the summer raises sum_done again.
// Ports:
//   clk, reset         clock, asynchronous active-high reset
//   in_valid/in_ready  upstream handshake; in_data word, in_last ends a short frame
//   data_array         frame to the summer, word 0 in the low slot
//   start              one-cycle launch pulse
//   sum_done           summer completion flag; only its rising edge releases
//   busy               frame launched and awaiting completion
//   short_frame        one-cycle pulse alongside start when the frame was padded
//   frames_launched    wrapping count of start pulses
module series_frame_loader
    import series_pkg::*;
#(
    parameter int unsigned N          = 10,
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               in_valid,
    input  logic [DATA_WIDTH-1:0]              in_data,
    input  logic                               in_last,
    output logic                               in_ready,
    output logic [N-1:0][DATA_WIDTH-1:0]       data_array,
    output logic                               start,
    input  logic                               sum_done,
    output logic                               busy,
    output logic                               short_frame,
    output logic [CNT_WIDTH-1:0]               frames_launched
);

    localparam int unsigned     IDX_W    = $clog2(N);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

    loader_state_t                   state_q, state_d;
    logic [IDX_W-1:0]                wr_idx_q, wr_idx_d;
    logic [N-1:0][DATA_WIDTH-1:0]    array_q, array_d;
    logic [CNT_WIDTH-1:0]            frames_q, frames_d;
    logic                            done_q;
    logic                            start_q, start_d;
    logic                            busy_q, busy_d;
    logic                            short_q, short_d;
    logic                            ready_q, ready_d;

    // State, frame storage and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= FILL;
            wr_idx_q <= '0;
            array_q  <= '0;
            frames_q <= '0;
            done_q   <= 1'b0;
            start_q  <= 1'b0;
            busy_q   <= 1'b0;
            short_q  <= 1'b0;
            ready_q  <= 1'b1;
        end else begin
            state_q  <= state_d;
            wr_idx_q <= wr_idx_d;
            array_q  <= array_d;
            frames_q <= frames_d;
            done_q   <= sum_done;
            start_q  <= start_d;
            busy_q   <= busy_d;
            short_q  <= short_d;
            ready_q  <= ready_d;
        end
    end

    // Next-state: fill, pad, launch, and wait for a fresh sum_done edge.
    always_comb begin
        state_d  = state_q;
        wr_idx_d = wr_idx_q;
        array_d  = array_q;
        frames_d = frames_q;
        start_d  = 1'b0;
        short_d  = 1'b0;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    array_d[wr_idx_q] = in_data;
                    if (wr_idx_q == LAST_IDX) begin
                        state_d = LAUNCH;
                    end else if (in_last) begin
                        // Zero the tail so stale words never reach the sum.
                        for (int unsigned i = 0; i < N; i++) begin
                            if (i > 32'(wr_idx_q)) begin
                                array_d[i] = '0;
                            end
                        end
                        short_d = 1'b1;
                        state_d = LAUNCH;
                    end else begin
                        wr_idx_d = wr_idx_q + IDX_W'(1);
                    end
                    // start and the count move together on entry to LAUNCH.
                    if (state_d == LAUNCH) begin
                        start_d  = 1'b1;
                        frames_d = frames_q + CNT_WIDTH'(1);
                    end
                end
            end
            LAUNCH: begin
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                // A level carried over from the previous frame does not release.
                if (sum_done && !done_q) begin
                    state_d  = FILL;
                    wr_idx_d = '0;
                end
            end
            default: begin
                state_d  = FILL;
                wr_idx_d = '0;
            end
        endcase
    end

    assign ready_d = (state_d == FILL);
    assign busy_d  = (state_d == WAIT_DONE);

    assign in_ready        = ready_q;
    assign data_array      = array_q;
    assign start           = start_q;
    assign busy            = busy_q;
    assign short_frame     = short_q;
    assign frames_launched = frames_q;

endmodule : series_frame_loader

// File: tb/tb_series_frame_loader.sv
// tb_series_frame_loader: scoreboard bench for series_frame_loader.
// The driver pushes the expected frame for every launch; a monitor pops and
// compares on each start pulse; a summer model answers with sum_done.
// The counter is built narrow so that wrap-around is reached quickly.
module tb_series_frame_loader;
    import series_pkg::*;

    localparam int unsigned N  = 10;
    localparam int unsigned DW = DEFAULT_DATA_WIDTH;
    localparam int unsigned CW = 4;

    typedef logic [N-1:0][DW-1:0] frame_t;
    typedef struct {
        frame_t           arr;
        bit               short_f;
        int unsigned      cnt;
        longint unsigned  sum;
        int unsigned      cyc;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic [DW-1:0]   in_data;
    logic            in_last;
    logic            in_ready;
    frame_t          data_array;
    logic            start;
    logic            sum_done;
    logic            busy;
    logic            short_frame;
    logic [CW-1:0]   frames_launched;

    int unsigned     total = 0;
    int unsigned     bad   = 0;
    int unsigned     cyc   = 0;
    int unsigned     model_cnt = 0;
    exp_t            expq[$];
    data_word_t      words[$];

    series_frame_loader #(.N(N), .DATA_WIDTH(DW), .CNT_WIDTH(CW)) dut (
        .clk             (clk),
        .reset           (reset),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_last         (in_last),
        .in_ready        (in_ready),
        .data_array      (data_array),
        .start           (start),
        .sum_done        (sum_done),
        .busy            (busy),
        .short_frame     (short_frame),
        .frames_launched (frames_launched)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [N*DW-1:0] got, input logic [N*DW-1:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Present one word and hold it until the loader takes it.
    task automatic send_word(input data_word_t d, input logic last, input bit final_w, input exp_t e);
        int unsigned waited = 0;
        exp_t        ee;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (in_ready !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got in_ready=%b expected 1 within 200 cycles", in_ready);
        end
        if (final_w) begin
            ee        = e;
            model_cnt = (model_cnt + 1) % (1 << CW);
            ee.cnt    = model_cnt;
            ee.cyc    = cyc + 1;
            expq.push_back(ee);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_data  = '0;
    endtask

    // Send the words queue as one frame; optionally poke 0xDEAD while it is held.
    task automatic send_frame(input bit last_on_full, input bit poke, input bit gaps);
        exp_t        e;
        int unsigned len = words.size();
        bit          fin;
        e.arr = '0;
        e.sum = 0;
        e.cnt = 0;
        e.cyc = 0;
        for (int unsigned i = 0; i < len; i++) begin
            e.arr[i] = words[i];
            e.sum    += longint'(words[i]);
        end
        e.short_f = (len < N);
        for (int unsigned i = 0; i < len; i++) begin
            fin = (i == len - 1);
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(negedge clk);
            end
            send_word(words[i], fin && (e.short_f || last_on_full), fin, e);
        end
        if (poke) begin
            in_valid = 1'b1;
            in_data  = 32'hDEAD;
            repeat (2) begin
                @(negedge clk);
                chk("poke_ready", in_ready, 0);
                chk("poke_frozen", data_array, e.arr);
            end
            in_valid = 1'b0;
            in_data  = '0;
        end
    endtask

    // Monitor: every start pulse is matched against the oldest expected frame.
    initial begin : monitor
        exp_t            e;
        longint unsigned s;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && start === 1'b1) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL start_spurious: got start=1 expected no launch pending");
                end else begin
                    e = expq.pop_front();
                    s = 0;
                    for (int unsigned i = 0; i < N; i++) s += longint'(data_array[i]);
                    chk("frame_data", data_array, e.arr);
                    chk("short_frame", short_frame, e.short_f);
                    chk("frames_launched", frames_launched, e.cnt);
                    chk("start_latency", cyc, e.cyc);
                    chk("frame_sum", s, e.sum);
                end
            end else if (reset === 1'b0 && short_frame === 1'b1) begin
                total++;
                bad++;
                $display("FAIL short_stray: got short_frame=1 expected 0 without start");
            end
        end
    end

    // Summer model: waits a few cycles, then produces a fresh rising edge.
    // After the first frame it leaves sum_done high to test carry-over.
    initial begin : summer
        int unsigned hold;
        int unsigned seen = 0;
        sum_done = 1'b0;
        forever begin
            @(negedge clk);
            if (reset === 1'b0 && start === 1'b1) begin
                seen++;
                hold = $urandom_range(2, 5);
                for (int unsigned i = 0; i < hold; i++) begin
                    @(negedge clk);
                    chk("busy_wait", busy, 1);
                    chk("ready_wait", in_ready, 0);
                end
                if (sum_done) begin
                    sum_done = 1'b0;
                    @(negedge clk);
                    chk("busy_after_drop", busy, 1);
                end
                sum_done = 1'b1;
                @(negedge clk);
                chk("ready_release", in_ready, 1);
                chk("busy_release", busy, 0);
                if (seen != 1 && $urandom_range(0, 1) == 0) sum_done = 1'b0;
            end
        end
    end

    initial begin : watchdog
        #300000;
        $display("FAIL watchdog: got no end of test expected finish before 300000 time units");
        $fatal(1, "watchdog expired");
    end

    initial begin : driver
        int unsigned len;
        int unsigned waited;
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        in_last  = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_start", start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_short", short_frame, 0);
        chk("rst_count", frames_launched, 0);
        chk("rst_array", data_array, '0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", in_ready, 1);

        // Full frame 1..10 back-to-back, sum 55.
        words.delete();
        for (int unsigned i = 1; i <= N; i++) words.push_back(data_word_t'(i));
        send_frame(1'b0, 1'b0, 1'b0);

        // Short frame of five 7s, sum 35; meets the carried-over sum_done.
        words.delete();
        repeat (5) words.push_back(32'd7);
        send_frame(1'b0, 1'b0, 1'b0);

        // Full random frame with in_last on the tenth word and a 0xDEAD poke.
        words.delete();
        repeat (N) words.push_back($urandom);
        send_frame(1'b1, 1'b1, 1'b0);

        // Reset after four accepted words discards the partial frame.
        for (int unsigned i = 0; i < 4; i++) begin
            send_word(32'd9, 1'b0, 1'b0, '{default: '0});
        end
        reset = 1'b1;
        #1;
        model_cnt = 0;
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_start", start, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_short", short_frame, 0);
        chk("midrst_count", frames_launched, 0);
        chk("midrst_array", data_array, '0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Full frame of 2s, sum 20.
        words.delete();
        repeat (N) words.push_back(32'd2);
        send_frame(1'b0, 1'b0, 1'b0);

        // Random frames; enough of them to wrap the narrow counter.
        for (int unsigned f = 0; f < 30; f++) begin
            words.delete();
            len = $urandom_range(1, N);
            repeat (len) words.push_back($urandom);
            send_frame($urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0, 1'b1);
        end

        waited = 0;
        while (in_ready !== 1'b1 && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        chk("final_ready", in_ready, 1);
        repeat (3) @(negedge clk);
        chk("queue_empty", expq.size(), 0);
        chk("final_count", frames_launched, model_cnt);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_series_frame_loader
